rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/sonata_pkg.sv | 28 ++
 rtl/rst_btn_debounce.sv | 40 ++++
 rtl/rst_sequencer.sv | 138 +++++++++++++
 tb/tb_rst_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sonata_pkg.sv
// rtl/sonata_pkg.sv - shared state codes and cause-bit layout for the reset sequencer
package sonata_pkg;

    localparam int StateW = 3;

    localparam logic [StateW-1:0] ST_ASSERT    = 3'd0;
    localparam logic [StateW-1:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [StateW-1:0] ST_HOLD      = 3'd2;
    localparam logic [StateW-1:0] ST_RELEASE   = 3'd3;
    localparam logic [StateW-1:0] ST_RUN       = 3'd4;

    localparam int CausePor     = 0;
    localparam int CauseBtn     = 1;
    localparam int CauseSw      = 2;
    localparam int CausePllLoss = 3;

    // A fresh trigger never carries the power-on bit; that one only comes from rst_i.
    function automatic logic [3:0] cause_vec(input logic pll_loss, input logic sw, input logic btn);
        logic [3:0] c;
        c               = 4'b0000;
        c[CausePllLoss] = pll_loss;
        c[CauseSw]      = sw;
        c[CauseBtn]     = btn;
        c[CausePor]     = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/rst_btn_debounce.sv
// rtl/rst_btn_debounce.sv - two-flop synchroniser and saturating debounce for the reset button
module rst_btn_debounce #(
    parameter int DebounceCycles = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);

    logic            btn_meta;
    logic            btn_s;
    logic [CntW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            cnt      <= '0;
            btn_db   <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
            if (!btn_s) begin
                cnt    <= '0;
                btn_db <= 1'b0;
            end else begin
                if (cnt != CntMax) begin
                    cnt <= cnt + 1'b1;
                end
                // This sample is the DebounceCycles-th consecutive high one.
                btn_db <= (cnt >= CntMax - 1'b1);
            end
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged multi-domain reset release with cause capture
module rst_sequencer
    import sonata_pkg::*;
#(
    parameter int NumDomains     = 3,
    parameter int DebounceCycles = 16,
    parameter int HoldCycles     = 255,
    parameter int StaggerCycles  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pll_locked_i,
    input  logic                  rst_btn_i,
    input  logic                  sw_rst_req_i,
    output logic [NumDomains-1:0] rst_no,
    output logic [3:0]            rst_cause_o,
    output logic                  busy_o
);

    localparam int HoldW = $clog2(HoldCycles + 1);
    localparam int StagW = $clog2(StaggerCycles + 1);
    localparam int IdxW  = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);
    localparam logic [StagW-1:0] StagLast = StagW'(StaggerCycles - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumDomains - 1);

    logic              pll_meta;
    logic              lock_s;
    logic              btn_db;
    logic [StateW-1:0] state;
    logic [HoldW-1:0]  hold_cnt;
    logic [StagW-1:0]  stag_cnt;
    logic [IdxW-1:0]   dom_idx;
    logic              any_trig;
    logic [3:0]        trig_cause;

    rst_btn_debounce #(
        .DebounceCycles(DebounceCycles)
    ) u_btn_debounce (
        .clk    (clk_i),
        .rst    (rst_i),
        .btn_raw(rst_btn_i),
        .btn_db (btn_db)
    );

    // Trigger set seen once at least one lock has been obtained (HOLD/RELEASE/RUN).
    assign any_trig   = btn_db | sw_rst_req_i | ~lock_s;
    assign trig_cause = cause_vec(~lock_s, sw_rst_req_i, btn_db);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pll_meta    <= 1'b0;
            lock_s      <= 1'b0;
            state       <= ST_ASSERT;
            rst_no      <= '0;
            rst_cause_o <= 4'b0001;
            busy_o      <= 1'b1;
            hold_cnt    <= '0;
            stag_cnt    <= '0;
            dom_idx     <= '0;
        end else begin
            pll_meta <= pll_locked_i;
            lock_s   <= pll_meta;
            case (state)
                ST_ASSERT: begin
                    if (!btn_db) begin
                        state <= ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (btn_db) begin
                        state       <= ST_ASSERT;
                        rst_cause_o <= cause_vec(1'b0, 1'b0, 1'b1);
                    end else if (lock_s) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (btn_db || sw_rst_req_i) begin
                        state       <= ST_ASSERT;
                        rst_cause_o <= trig_cause;
                    end else if (!lock_s) begin
                        // Nothing released yet, so just go back to waiting for lock.
                        state       <= ST_WAIT_LOCK;
                        hold_cnt    <= '0;
                        rst_cause_o <= trig_cause;
                    end else if (hold_cnt == HoldLast) begin
                        rst_no   <= NumDomains'(1);
                        stag_cnt <= '0;
                        dom_idx  <= IdxW'(1);
                        if (NumDomains == 1) begin
                            state  <= ST_RUN;
                            busy_o <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (any_trig) begin
                        state       <= ST_ASSERT;
                        rst_no      <= '0;
                        rst_cause_o <= trig_cause;
                    end else if (stag_cnt == StagLast) begin
                        rst_no   <= rst_no | (NumDomains'(1) << dom_idx);
                        stag_cnt <= '0;
                        if (dom_idx == IdxLast) begin
                            state  <= ST_RUN;
                            busy_o <= 1'b0;
                        end else begin
                            dom_idx <= dom_idx + 1'b1;
                        end
                    end else begin
                        stag_cnt <= stag_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (any_trig) begin
                        state       <= ST_ASSERT;
                        rst_no      <= '0;
                        busy_o      <= 1'b1;
                        rst_cause_o <= trig_cause;
                    end
                end
                default: begin
                    state  <= ST_ASSERT;
                    rst_no <= '0;
                    busy_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - randomized and directed checks of rst_sequencer against a timeline model
module tb_rst_sequencer;

    localparam int N = 3;
    localparam int D = 4;
    localparam int H = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         pll;
    logic         btn;
    logic         sw;
    logic [N-1:0] rst_no;
    logic [3:0]   cause;
    logic         busy;

    int errors = 0;
    int checks = 0;

    rst_sequencer #(
        .NumDomains    (N),
        .DebounceCycles(D),
        .HoldCycles    (H),
        .StaggerCycles (S)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pll_locked_i(pll),
        .rst_btn_i   (btn),
        .sw_rst_req_i(sw),
        .rst_no      (rst_no),
        .rst_cause_o (cause),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = held in reset, 1 = waiting for lock, 2 = timeline running.
    // In phase 2, m_el counts edges since the lock was seen; release times follow from it.
    bit       m_valid = 1'b0;
    bit       m_p1, m_lock, m_b1, m_bs, m_db;
    int       m_run;
    int       m_phase;
    int       m_el;
    bit [3:0] m_cause;

    function automatic logic [N-1:0] exp_rst_no();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (m_phase == 2) && (m_el >= H + 1 + i * S);
        end
        return r;
    endfunction

    function automatic logic exp_busy();
        return !((m_phase == 2) && (m_el >= H + 1 + (N - 1) * S));
    endfunction

    task automatic model_step();
        if (rst) begin
            m_valid = 1'b1;
            m_phase = 0;
            m_el    = 0;
            m_cause = 4'b0001;
            m_p1 = 0; m_lock = 0; m_b1 = 0; m_bs = 0; m_db = 0; m_run = 0;
        end else begin
            case (m_phase)
                0: if (!m_db) m_phase = 1;
                1: begin
                    if (m_db) begin
                        m_phase = 0;
                        m_cause = 4'b0010;
                    end else if (m_lock) begin
                        m_phase = 2;
                        m_el    = 1;
                    end
                end
                default: begin
                    if (m_db || sw || !m_lock) begin
                        m_cause = {!m_lock, sw, m_db, 1'b0};
                        m_phase = (!m_db && !sw && m_el <= H) ? 1 : 0;
                    end else if (m_el < 1000) begin
                        m_el = m_el + 1;
                    end
                end
            endcase
            m_run  = m_bs ? m_run + 1 : 0;
            m_db   = (m_run >= D);
            m_bs   = m_b1;
            m_b1   = btn;
            m_lock = m_p1;
            m_p1   = pll;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("model_rst_no", 32'(rst_no), 32'(exp_rst_no()));
            check("model_cause", 32'(cause), 32'(m_cause));
            check("model_busy", 32'(busy), 32'(exp_busy()));
        end
    end

    initial begin
        bit seen;
        rst = 1'b1; pll = 1'b1; btn = 1'b0; sw = 1'b0;
        step(3);
        check("reset_rst_no", 32'(rst_no), 32'h0);
        check("reset_cause", 32'(cause), 32'h1);
        check("reset_busy", 32'(busy), 32'h1);
        rst = 1'b0;

        // Lock seen in WAIT_LOCK two edges after reset drops: domains at edges 11, 13, 15.
        for (int n = 1; n <= 15; n++) begin
            step(1);
            if (n == 10) check("rel_e10", 32'(rst_no), 32'h0);
            if (n == 11) check("rel_e11", 32'(rst_no), 32'h1);
            if (n == 12) check("rel_e12", 32'(rst_no), 32'h1);
            if (n == 13) check("rel_e13", 32'(rst_no), 32'h3);
            if (n == 14) check("busy_e14", 32'(busy), 32'h1);
            if (n == 15) check("rel_e15", 32'(rst_no), 32'h7);
            if (n == 15) check("busy_e15", 32'(busy), 32'h0);
        end
        step(3);

        btn = 1'b1; step(3); btn = 1'b0; step(8);
        check("short_btn_rst_no", 32'(rst_no), 32'h7);
        check("short_btn_cause", 32'(cause), 32'h1);

        btn = 1'b1; step(6);
        check("btn_pre_rst_no", 32'(rst_no), 32'h7);
        step(1);
        check("btn_rst_no", 32'(rst_no), 32'h0);
        check("btn_cause", 32'(cause), 32'h2);
        step(5);
        check("btn_held_busy", 32'(busy), 32'h1);
        btn = 1'b0; step(30);
        check("btn_rerelease", 32'(rst_no), 32'h7);

        sw = 1'b1; step(1); sw = 1'b0;
        check("sw_rst_no", 32'(rst_no), 32'h0);
        check("sw_cause", 32'(cause), 32'h4);
        step(30);
        check("sw_rerelease", 32'(rst_no), 32'h7);

        sw = 1'b1; step(1); sw = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1);
            seen = rst_no[0];
        end
        check("dom0_released", 32'(seen), 32'h1);
        pll = 1'b0; step(3);
        check("pll_loss_rst_no", 32'(rst_no), 32'h0);
        check("pll_loss_cause", 32'(cause), 32'h8);
        step(20);
        check("pll_wait_rst_no", 32'(rst_no), 32'h0);
        check("pll_wait_busy", 32'(busy), 32'h1);
        pll = 1'b1; step(30);
        check("relock_rst_no", 32'(rst_no), 32'h7);

        btn = 1'b1; step(6); sw = 1'b1; step(1); sw = 1'b0;
        check("both_cause", 32'(cause), 32'h6);
        check("both_rst_no", 32'(rst_no), 32'h0);
        btn = 1'b0; step(30);

        sw = 1'b1; step(1); sw = 1'b0; step(4);
        rst = 1'b1; step(1); rst = 1'b0;
        check("hold_rst_cause", 32'(cause), 32'h1);
        check("hold_rst_rst_no", 32'(rst_no), 32'h0);
        check("hold_rst_busy", 32'(busy), 32'h1);

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 89) == 0) pll = ~pll;
            if ($urandom_range(0, 39) == 0) btn = ~btn;
            sw = ($urandom_range(0, 69) == 0);
            step(1);
        end
        rst = 1'b0; btn = 1'b0; sw = 1'b0; pll = 1'b1;
        step(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
